seven_segment_reader: RTL
=========================

SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, the number of consecutive identical synchronized samples required to capture a digit (legal range 2..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port SegIn, input, 7 bits: active-high segment lines {a,b,c,d,e,f,g}, a = MSB, asynchronous to clk.
REQ-005 SHALL have port DigitSel, input, 4 bits: active-high digit enables of a scanned 4-digit display, bit 0 = least significant digit, asynchronous to clk.
REQ-006 SHALL have port BCDOut, output, 16 bits: one 4-bit code per digit, digit i at bits [4i+3:4i].
REQ-007 SHALL have port DigitErr, output, 4 bits: bit i set when digit i held an unrecognised pattern in the presented frame.
REQ-008 SHALL have port FrameValid, output, 1 bit: BCDOut and DigitErr hold a complete frame.
REQ-009 SHALL have port FrameReady, input, 1 bit: consumer accepts the frame.
REQ-010 SHALL have port Overrun, output, 1 bit: sticky flag, a completed frame was dropped.

Function
REQ-011 SHALL pass SegIn and DigitSel through a 2-flop synchronizer before any other use.
REQ-012 SHALL decode patterns as: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-013 SHALL decode 0000000 to code 4'hF (blank) with no error, and any other pattern to code 4'hE with the error bit set.
REQ-014 SHALL run a per-sample FSM with three states: IDLE, SETTLE and HELD.
REQ-015 In IDLE, a synchronized DigitSel that is exactly one-hot SHALL load the stability counter with 1 and move to SETTLE.
REQ-016 In SETTLE, each cycle with synchronized {SegIn,DigitSel} equal to the previous cycle SHALL increment the counter.
REQ-017 In SETTLE, any change SHALL return to IDLE in the same cycle, and that cycle's sample SHALL be re-evaluated as in REQ-015.
REQ-018 When the counter reaches STABLE_CYCLES, the block SHALL store the decoded code and error bit into slot i (the selected digit), set capture-mask bit i and enter HELD.
REQ-019 In HELD, the block SHALL not re-capture; any change of DigitSel or SegIn SHALL return to IDLE.
REQ-020 DigitSel equal to zero or multi-hot SHALL never capture and SHALL hold the FSM in IDLE.
REQ-021 Re-capture of a digit already in the mask before frame completion SHALL overwrite its slot.
REQ-022 When all 4 mask bits are set, the block SHALL move the slots to BCDOut/DigitErr and assert FrameValid on the next cycle, then clear the mask.
REQ-023 While FrameValid=1, BCDOut and DigitErr SHALL be stable.
REQ-024 FrameValid SHALL deassert on the cycle after clk samples FrameValid=1 and FrameReady=1.
REQ-025 A new frame completing in the same cycle as acceptance SHALL be loaded, and FrameValid SHALL stay 1.
REQ-026 A frame completing while FrameValid=1 and FrameReady=0 SHALL be dropped and SHALL set Overrun; Overrun SHALL be cleared only by reset.
REQ-027 The stability counter SHALL be 4 bits wide and SHALL saturate, never wrapping.
REQ-028 Minimum latency from a stable, one-hot input change to capture SHALL be 2 + STABLE_CYCLES cycles.

Reset
REQ-029 On rst low, the following SHALL clear asynchronously: BCDOut=16'hFFFF, DigitErr=0, FrameValid=0, Overrun=0, mask=0, counter=0, FSM=IDLE, synchronizers=0.
REQ-030 Reset mid-frame SHALL discard partial captures; operation SHALL resume on the first clk edge after rst is released.

Verification
REQ-031 Scan digits 1,2,3,4 (DigitSel 0001..1000, patterns 0110000,1101101,1111001,0110011), 8 cycles each, FrameReady=1 -> one FrameValid pulse, BCDOut=16'h4321, DigitErr=0.
REQ-032 Digit 2 pattern 1000001 with others 0 -> BCDOut nibble 2 = 4'hE, DigitErr=4'b0100.
REQ-033 Digit held only STABLE_CYCLES-1 cycles, or toggling DigitSel=0011 -> no capture and no FrameValid.
REQ-034 FrameReady=0 across two full scans -> first frame held stable, second dropped, Overrun=1.
REQ-035 Assert rst after 2 digits captured, then scan 4 digits -> exactly one frame containing only post-reset values.
REQ-036 Blank digit 3 (0000000) with digits 0-2 showing 5 -> BCDOut=16'hF555, DigitErr=0.

Source files
------------

// File: rtl/seven_segment_reader.sv
// Samples the segment and digit-select lines of a scanned 4-digit 7-segment display and
// rebuilds complete BCD frames, handed to a consumer through a valid/ready handshake.
module seven_segment_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  SegIn,
    input  logic [3:0]  DigitSel,
    input  logic        FrameReady,
    output logic [15:0] BCDOut,
    output logic [3:0]  DigitErr,
    output logic        FrameValid,
    output logic        Overrun
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

    // Returns {error, code} for one segment pattern {a,b,c,d,e,f,g}.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1111110: r = {1'b0, 4'h0};
            7'b0110000: r = {1'b0, 4'h1};
            7'b1101101: r = {1'b0, 4'h2};
            7'b1111001: r = {1'b0, 4'h3};
            7'b0110011: r = {1'b0, 4'h4};
            7'b1011011: r = {1'b0, 4'h5};
            7'b1011111: r = {1'b0, 4'h6};
            7'b1110000: r = {1'b0, 4'h7};
            7'b1111111: r = {1'b0, 4'h8};
            7'b1111011: r = {1'b0, 4'h9};
            7'b0000000: r = {1'b0, 4'hF};
            default:    r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    logic [6:0]  seg_meta_q, seg_sync_q;
    logic [3:0]  sel_meta_q, sel_sync_q;
    logic [10:0] prev_q;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  cnt_inc_s;
    logic [15:0] slot_code_q, slot_code_d;
    logic [3:0]  slot_err_q, slot_err_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  err_q, err_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;
    logic        onehot_s, same_s, cap_s, frame_full_s;
    logic [4:0]  dec_s;

    assign onehot_s     = is_onehot(sel_sync_q);
    assign same_s       = ({seg_sync_q, sel_sync_q} == prev_q);
    assign dec_s        = decode_seg(seg_sync_q);
    assign frame_full_s = &mask_q;
    assign cnt_inc_s    = (cnt_q == 4'hF) ? 4'hF : (cnt_q + 4'd1);

    // Two-flop synchronizers for the display lines, which run off their own clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_meta_q <= 7'd0;
            seg_sync_q <= 7'd0;
            sel_meta_q <= 4'd0;
            sel_sync_q <= 4'd0;
        end else begin
            seg_meta_q <= SegIn;
            seg_sync_q <= seg_meta_q;
            sel_meta_q <= DigitSel;
            sel_sync_q <= sel_meta_q;
        end
    end

    // Stability FSM: a change always drops back to IDLE and re-qualifies the same sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (onehot_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            ST_SETTLE: begin
                if (same_s) begin
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s >= STABLE_CNT) begin
                        cap_s   = 1'b1;
                        state_d = ST_HELD;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end else if (onehot_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            ST_HELD: begin
                if (same_s) begin
                    state_d = ST_HELD;
                end else if (onehot_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Slot capture; the one-hot select doubles as the write enable per digit.
    always_comb begin
        slot_code_d = slot_code_q;
        slot_err_d  = slot_err_q;
        for (int i = 0; i < 4; i++) begin
            if (cap_s && sel_sync_q[i]) begin
                slot_code_d[4*i +: 4] = dec_s[3:0];
                slot_err_d[i]         = dec_s[4];
            end else begin
                slot_code_d[4*i +: 4] = slot_code_q[4*i +: 4];
                slot_err_d[i]         = slot_err_q[i];
            end
        end
        mask_d = (frame_full_s ? 4'd0 : mask_q) | (cap_s ? sel_sync_q : 4'd0);
    end

    // Frame hand-off: load when the output is free or being accepted, otherwise drop.
    always_comb begin
        bcd_d   = bcd_q;
        err_d   = err_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (frame_full_s) begin
            if (!valid_q || FrameReady) begin
                bcd_d   = slot_code_q;
                err_d   = slot_err_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && FrameReady) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State, slot and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q      <= 11'd0;
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            slot_code_q <= 16'hFFFF;
            slot_err_q  <= 4'd0;
            mask_q      <= 4'd0;
            bcd_q       <= 16'hFFFF;
            err_q       <= 4'd0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            prev_q      <= {seg_sync_q, sel_sync_q};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slot_code_q <= slot_code_d;
            slot_err_q  <= slot_err_d;
            mask_q      <= mask_d;
            bcd_q       <= bcd_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign BCDOut     = bcd_q;
    assign DigitErr   = err_q;
    assign FrameValid = valid_q;
    assign Overrun    = ovr_q;

endmodule
